// File: rtl/frog_pkg.sv
// Shared types and constants for the frog sprite fetch stage.
package frog_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  typedef enum logic {
    IDLE = 1'b0,
    JUMP = 1'b1
  } anim_state_t;

  localparam int FROG_SPRITE_W    = 40;
  localparam int FROG_FRAME_SZ    = 1600;
  localparam int FROG_JUMP_FRAMES = 8;

endpackage

// File: rtl/frog_anim_fsm.sv
// Hop animation FSM: frame_clk edge detect, jump frame counter, latched facing.
module frog_anim_fsm
  import frog_pkg::*;
#(
  parameter int JUMP_FRAMES = FROG_JUMP_FRAMES
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       hop,
  input  logic [1:0] dir,
  output dir_t       dir_q,
  output logic       hop_busy
);

  localparam int CNT_W = $clog2(JUMP_FRAMES + 1);

  anim_state_t      r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  dir_t             r_dir_q, w_dir_next;
  logic             r_fclk_d;
  logic             w_fclk_rise;

  assign w_fclk_rise = frame_clk & ~r_fclk_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_dir_q  <= UP;
      r_fclk_d <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_dir_q  <= w_dir_next;
      r_fclk_d <= frame_clk;
    end
  end

  // Hops arriving while the jump frame is shown are dropped, never queued.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_dir_next   = r_dir_q;
    unique case (r_state)
      IDLE: begin
        if (hop) begin
          w_state_next = JUMP;
          w_cnt_next   = '0;
          w_dir_next   = dir_t'(dir);
        end
      end
      JUMP: begin
        if (w_fclk_rise) begin
          w_cnt_next = r_cnt + CNT_W'(1);
          if (w_cnt_next == CNT_W'(JUMP_FRAMES)) begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign dir_q    = r_dir_q;
  assign hop_busy = (r_state == JUMP);

endmodule

// File: rtl/frog_sprite_fetch.sv
// Frog sprite ROM address generation and 3-cycle scan realignment.
// Define FROG_ROTATE_EN to enable four-way facing by rotating the up-facing artwork.
module frog_sprite_fetch
  import frog_pkg::*;
#(
  parameter int         SPRITE_W    = FROG_SPRITE_W,
  parameter int         SPRITE_SZ   = FROG_FRAME_SZ,
  parameter int         JUMP_FRAMES = FROG_JUMP_FRAMES,
  parameter logic [3:0] TRANSP_IDX  = 4'h0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        hop,
  input  logic [1:0]  dir,
  input  logic [9:0]  FrogX,
  input  logic [9:0]  FrogY,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [11:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic        frog_on,
  output logic [3:0]  frog_idx,
  output logic        hop_busy
);

  localparam int                CW       = $clog2(SPRITE_W);
  localparam logic [CW-1:0]     EDGE_MAX = CW'(SPRITE_W - 1);

  dir_t          w_dir_q;
  logic [9:0]    w_col, w_row;
  logic          w_in_box;
  logic [CW-1:0] r_col, r_row;
  logic [2:0]    r_inbox;
  logic [CW-1:0] w_src_row, w_src_col;
  logic [11:0]   w_addr;
  logic          w_opaque;

  frog_anim_fsm #(
    .JUMP_FRAMES(JUMP_FRAMES)
  ) u_fsm (
    .Clk      (Clk),
    .Reset    (Reset),
    .frame_clk(frame_clk),
    .hop      (hop),
    .dir      (dir),
    .dir_q    (w_dir_q),
    .hop_busy (hop_busy)
  );

  // Unsigned wrap makes a scan position left of / above the frog fall out of the box.
  assign w_col    = DrawX - FrogX;
  assign w_row    = DrawY - FrogY;
  assign w_in_box = (w_col < 10'(SPRITE_W)) && (w_row < 10'(SPRITE_W));

`ifdef FROG_ROTATE_EN
  always_comb begin
    w_src_row = r_row;
    w_src_col = r_col;
    unique case (w_dir_q)
      UP: begin
        w_src_row = r_row;
        w_src_col = r_col;
      end
      DOWN: begin
        w_src_row = EDGE_MAX - r_row;
        w_src_col = EDGE_MAX - r_col;
      end
      LEFT: begin
        w_src_row = r_col;
        w_src_col = EDGE_MAX - r_row;
      end
      RIGHT: begin
        w_src_row = EDGE_MAX - r_col;
        w_src_col = r_row;
      end
    endcase
  end
`else
  logic w_unused_dir;
  assign w_unused_dir = ^w_dir_q;
  assign w_src_row    = r_row;
  assign w_src_col    = r_col;
`endif

  // The jump frame sits directly after the sitting frame in ROM.
  assign w_addr = (hop_busy ? 12'(SPRITE_SZ) : 12'd0)
                + 12'(w_src_row) * 12'(SPRITE_W)
                + 12'(w_src_col);

  assign w_opaque = r_inbox[2] && (rom_data != TRANSP_IDX);

  // r_inbox[0] tracks the coordinate stage, [2] lines up with rom_data.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_col    <= '0;
      r_row    <= '0;
      r_inbox  <= '0;
      rom_addr <= '0;
      frog_on  <= 1'b0;
      frog_idx <= '0;
    end else begin
      r_col    <= w_col[CW-1:0];
      r_row    <= w_row[CW-1:0];
      r_inbox  <= {r_inbox[1:0], w_in_box};
      rom_addr <= r_inbox[0] ? w_addr : 12'd0;
      frog_on  <= w_opaque;
      frog_idx <= w_opaque ? rom_data : 4'h0;
    end
  end

endmodule

// File: tb/tb_frog_sprite_fetch.sv
// Self-checking bench for frog_sprite_fetch: vector table, hop/reset sequences, random scan vs reference model.
module tb_frog_sprite_fetch;

  localparam int HMAX = 8192;
  localparam int JF   = 8;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic        hop = 1'b0;
  logic [1:0]  dir = 2'd0;
  logic [9:0]  FrogX = 10'd0, FrogY = 10'd0, DrawX = 10'd0, DrawY = 10'd0;
  logic [11:0] rom_addr;
  logic [3:0]  rom_data = 4'h0;
  logic        frog_on;
  logic [3:0]  frog_idx;
  logic        hop_busy;

  frog_sprite_fetch dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .frame_clk(frame_clk),
    .hop      (hop),
    .dir      (dir),
    .FrogX    (FrogX),
    .FrogY    (FrogY),
    .DrawX    (DrawX),
    .DrawY    (DrawY),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .frog_on  (frog_on),
    .frog_idx (frog_idx),
    .hop_busy (hop_busy)
  );

  always #5 Clk = ~Clk;

  logic [3:0] rom_mem [0:4095];
  always @(posedge Clk) rom_data <= rom_mem[rom_addr];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state
  bit         m_busy = 1'b0;
  int         m_cnt  = 0;
  logic [1:0] m_dir  = 2'd0;
  bit         m_prev = 1'b0;
  logic [11:0] h_addr [0:HMAX-1];
  bit          h_inb  [0:HMAX-1];
  bit          h_on   [0:HMAX-1];
  logic [3:0]  h_idx  [0:HMAX-1];

  typedef struct {
    logic [9:0]  fx, fy, dx, dy;
    logic [3:0]  rv;
    logic [11:0] ea;
    logic        eon;
    logic [3:0]  eidx;
  } vec_t;
  vec_t vecs [0:8];

  function automatic int hi(input int v);
    return v & (HMAX - 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: update model from the inputs seen at this edge, then compare DUT.
  task automatic tick();
    int c, r, sr, sc, a;
    bit inb;
    @(posedge Clk);
    if (Reset) begin
      m_busy = 1'b0; m_cnt = 0; m_dir = 2'd0; m_prev = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (cyc - k >= 0) begin
          h_addr[hi(cyc-k)] = 12'd0; h_inb[hi(cyc-k)] = 1'b0;
          h_on[hi(cyc-k)] = 1'b0;    h_idx[hi(cyc-k)] = 4'h0;
        end
      end
    end else begin
      if (!m_busy) begin
        if (hop) begin m_busy = 1'b1; m_cnt = 0; m_dir = dir; end
      end else if (frame_clk && !m_prev) begin
        m_cnt++;
        if (m_cnt == JF) m_busy = 1'b0;
      end
      m_prev = frame_clk;
      c = (int'(DrawX) - int'(FrogX)) & 1023;
      r = (int'(DrawY) - int'(FrogY)) & 1023;
      inb = (c < 40) && (r < 40);
      sr = r; sc = c;
`ifdef FROG_ROTATE_EN
      case (m_dir)
        2'd1: begin sr = 39 - r; sc = 39 - c; end
        2'd2: begin sr = c;      sc = 39 - r; end
        2'd3: begin sr = 39 - c; sc = r;      end
        default: begin sr = r; sc = c; end
      endcase
`endif
      a = inb ? ((m_busy ? 1600 : 0) + sr * 40 + sc) : 0;
      h_addr[hi(cyc)] = 12'(a);
      h_inb[hi(cyc)]  = inb;
    end
    // ROM is read at this edge for the pixel sampled two edges ago
    if (cyc >= 2) begin
      h_on[hi(cyc-2)]  = h_inb[hi(cyc-2)] && (rom_mem[h_addr[hi(cyc-2)]] != 4'h0);
      h_idx[hi(cyc-2)] = h_on[hi(cyc-2)] ? rom_mem[h_addr[hi(cyc-2)]] : 4'h0;
    end
    #1;
    if (cyc >= 3) begin
      chk("model_rom_addr", int'(rom_addr), int'(h_addr[hi(cyc-1)]));
      chk("model_frog_on",  int'(frog_on),  int'(h_on[hi(cyc-3)]));
      chk("model_frog_idx", int'(frog_idx), int'(h_idx[hi(cyc-3)]));
      chk("model_hop_busy", int'(hop_busy), int'(m_busy));
    end
    cyc++;
    @(negedge Clk);
  endtask

  task automatic fedge();
    frame_clk = 1'b1; tick();
    frame_clk = 1'b0; tick();
  endtask

  task automatic set_pos(input int fx, input int fy, input int dx, input int dy);
    FrogX = 10'(fx); FrogY = 10'(fy); DrawX = 10'(dx); DrawY = 10'(dy);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = 4'($urandom_range(0, 15));
    vecs[0] = '{10'd100,  10'd200, 10'd100, 10'd200, 4'd5,  12'd0,    1'b1, 4'd5};
    vecs[1] = '{10'd100,  10'd200, 10'd139, 10'd239, 4'd7,  12'd1599, 1'b1, 4'd7};
    vecs[2] = '{10'd100,  10'd200, 10'd99,  10'd200, 4'd9,  12'd0,    1'b0, 4'd0};
    vecs[3] = '{10'd100,  10'd200, 10'd140, 10'd200, 4'd9,  12'd0,    1'b0, 4'd0};
    vecs[4] = '{10'd100,  10'd200, 10'd101, 10'd202, 4'd0,  12'd81,   1'b0, 4'd0};
    vecs[5] = '{10'd100,  10'd200, 10'd100, 10'd239, 4'd15, 12'd1560, 1'b1, 4'd15};
    vecs[6] = '{10'd0,    10'd0,   10'd5,   10'd3,   4'd3,  12'd125,  1'b1, 4'd3};
    vecs[7] = '{10'd100,  10'd200, 10'd100, 10'd199, 4'd6,  12'd0,    1'b0, 4'd0};
    vecs[8] = '{10'd1020, 10'd0,   10'd2,   10'd0,   4'd11, 12'd6,    1'b1, 4'd11};

    set_pos(100, 200, 100, 200);
    Reset = 1'b1;
    repeat (4) tick();
    chk("reset_rom_addr", int'(rom_addr), 0);
    chk("reset_frog_on",  int'(frog_on),  0);
    chk("reset_frog_idx", int'(frog_idx), 0);
    chk("reset_hop_busy", int'(hop_busy), 0);
    Reset = 1'b0;

    // Vector table: frame 0, up-facing
    for (int v = 0; v < 9; v++) begin
      rom_mem[vecs[v].ea] = vecs[v].rv;
      set_pos(int'(vecs[v].fx), int'(vecs[v].fy), int'(vecs[v].dx), int'(vecs[v].dy));
      repeat (4) tick();
      chk($sformatf("vec%0d_rom_addr", v), int'(rom_addr), int'(vecs[v].ea));
      chk($sformatf("vec%0d_frog_on", v),  int'(frog_on),  int'(vecs[v].eon));
      chk($sformatf("vec%0d_frog_idx", v), int'(frog_idx), int'(vecs[v].eidx));
    end

    // Hop sequence with an ignored second hop
    set_pos(100, 200, 100, 200);
    dir = 2'd0;
    hop = 1'b1; tick(); hop = 1'b0;
    chk("hop_busy_rise", int'(hop_busy), 1);
    tick();
    chk("hop_jump_addr", int'(rom_addr), 1600);
    repeat (3) fedge();
    hop = 1'b1; tick(); hop = 1'b0;
    repeat (4) fedge();
    chk("hop_busy_after7", int'(hop_busy), 1);
    fedge();
    chk("hop_busy_after8", int'(hop_busy), 0);
    tick();
    chk("hop_idle_addr", int'(rom_addr), 0);

    // Hop facing left, then reset mid-jump
    dir = 2'd2;
    hop = 1'b1; tick(); hop = 1'b0; dir = 2'd0;
    tick();
`ifdef FROG_ROTATE_EN
    chk("left_jump_addr", int'(rom_addr), 1639);
`else
    chk("left_jump_addr", int'(rom_addr), 1600);
`endif
    tick();
    Reset = 1'b1; tick(); Reset = 1'b0;
    tick(); tick();
    chk("midjump_reset_addr", int'(rom_addr), 0);
    chk("midjump_reset_busy", int'(hop_busy), 0);

    // Randomized scan against the reference model
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        FrogX = ($urandom_range(0, 3) == 0) ? 10'(1000 + $urandom_range(0, 23))
                                            : 10'($urandom_range(0, 1023));
        FrogY = 10'($urandom_range(0, 1023));
      end
      DrawX = FrogX + 10'($urandom_range(0, 49)) - 10'd5;
      DrawY = FrogY + 10'($urandom_range(0, 49)) - 10'd5;
      hop   = ($urandom_range(0, 15) == 0);
      dir   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
      Reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    Reset = 1'b0; hop = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frog_sprite_fetch.md
# frog_sprite_fetch

Sprite fetch stage sitting directly upstream of the frog sprite ROM: takes the VGA scan position and frog state, generates the 12-bit ROM read address, and realigns the returned 4-bit palette index with the scan pipeline. Owns the hop animation FSM, which alternates between the sitting frame and the jump frame. Computes the facing direction from the single up-facing artwork by rotation. Downstream, the colour mapper consumes `frog_on`/`frog_idx`.

## Interface
- `SPRITE_W`, 40: sprite edge in pixels.
- `SPRITE_SZ`, 1600: words per sprite frame in ROM.
- `JUMP_FRAMES`, 8: `frame_clk` rising edges the jump frame is held.
- `TRANSP_IDX`, 4'h0: palette index treated as transparent.
- `Clk` in 1: single system clock.
- `Reset` in 1: synchronous, active-high.
- `frame_clk` in 1: vsync-rate level signal; rising edge detected internally on `Clk`.
- `hop` in 1: one-cycle hop request.
- `dir` in 2: requested facing; 00 up, 01 down, 10 left, 11 right.
- `FrogX`, `FrogY` in 10 each: sprite top-left pixel.
- `DrawX`, `DrawY` in 10 each: current scan pixel.
- `rom_addr` out 12: ROM read address, registered.
- `rom_data` in 4: ROM output, valid one `Clk` after `rom_addr`.
- `frog_on` out 1: current pixel is an opaque frog pixel.
- `frog_idx` out 4: palette index. Forced to 0 when `frog_on`=0.
- `hop_busy` out 1: high while FSM is in JUMP.

## Operation
- FSM states:
  - IDLE: frame 0. On `hop`, go to JUMP: latch `dir` into `dir_q`, clear the frame counter.
  - JUMP: frame 1. The frame counter increments on each `frame_clk` rising edge. When it reaches `JUMP_FRAMES`, go to IDLE.
- `hop` while in JUMP is ignored; it is not queued. `hop` in the same cycle as JUMP→IDLE is also ignored.
- Local coordinates: c = `DrawX`−`FrogX`, r = `DrawY`−`FrogY`, both 10-bit unsigned wrap. In box when c<40 and r<40; wrap makes `DrawX`<`FrogX` out of box.
- Source pixel selected by `dir_q`:
  - up: (r, c)
  - down: (39−r, 39−c)
  - left: (c, 39−r)
  - right: (39−c, r)
- Address = frame·1600 + src_row·40 + src_col. Maximum is 3199, which fits 12 bits. Out of box, address = 0.
- Output: `frog_on` = in_box_delayed && `rom_data`≠`TRANSP_IDX`. `frog_idx` = `rom_data` when `frog_on`=1, else 0.
- Reset values: IDLE, `dir_q`=up, counter 0, `rom_addr`=0, `frog_on`=0, `frog_idx`=0, `hop_busy`=0, in-box delay pipeline cleared.
- Reset asserted mid-jump aborts the jump immediately. The next fetch uses frame 0.

## Timing
- Scan position sampled at edge n produces `rom_addr` valid after edge n+1.
- `rom_data` is valid after edge n+2.
- `frog_on`/`frog_idx` are registered and valid after edge n+3. Total latency is 3 `Clk` cycles.
- The in-box flag is delayed 2 stages to align with `rom_data`.
- Frame select and `dir_q` are sampled in the same stage as address generation. A frame change affects pixels from the next address onward.
- `hop_busy` rises the cycle after `hop` is accepted. It falls the cycle after the final `frame_clk` edge.
- `frame_clk` edges are detected with a 1-cycle registered compare. An edge coinciding with `hop` acceptance does not count.

## Configuration
- `FROG_ROTATE_EN` defined: four-way rotation as specified above.
- Undefined: `dir` and `dir_q` are ignored, and the source is always (r, c), i.e. up-facing. The FSM, latency and all ports are unchanged.

## Structure
- Shared package `frog_pkg` holds:
  - `dir_t` enum (UP, DOWN, LEFT, RIGHT)
  - `anim_state_t` (IDLE, JUMP)
  - constants for sprite width and frame size
- Sub-module `frog_anim_fsm` contains the FSM, `frame_clk` edge detect, counter, `dir_q` and `hop_busy`. Address generation and the alignment pipeline stay in the top.

## Test plan
- Reset, `FrogX`=100, `FrogY`=200, `DrawX`=100, `DrawY`=200 → `rom_addr`=0 at n+1; `rom_data`=5 → `frog_on`=1, `frog_idx`=5 at n+3.
- Same frog, `DrawX`=139, `DrawY`=239 → `rom_addr`=1599.
- `DrawX`=99 or 140 → `frog_on`=0, `frog_idx`=0 regardless of `rom_data`.
- `rom_data`=0 in box → `frog_on`=0.
- Hop sequence:
  - `hop` → `hop_busy`=1; scan at (100,200) gives `rom_addr`=1600.
  - Second `hop` during JUMP is ignored.
  - After 8 `frame_clk` edges → `hop_busy`=0 and `rom_addr`=0.
- With `FROG_ROTATE_EN`:
  - hop with `dir`=left, scan (100,200) → addr 1639.
  - Reset mid-jump → next fetch at (100,200) gives 0 and `hop_busy`=0.
